// File: rtl/apb_txn_monitor.sv
// Passive APB monitor: follows SETUP/ACCESS phases per sampled bus cycle and emits one registered
// record per completed transfer, plus sticky protocol-violation flags and a saturating transfer count.
module apb_txn_monitor #(
   parameter int  ADDR_W   = 32,
   parameter int  DATA_W   = 32,
   parameter int  NUM_SLV  = 3,
   parameter int  MAX_WAIT = 16,
   parameter int  CNT_W    = 16,
   localparam int SLV_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
   localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0] PSEL,
   input  logic              PWRITE,
   input  logic              PENABLE,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic              viol_clr,
   output logic              txn_valid,
   output logic [ADDR_W-1:0] txn_addr,
   output logic [DATA_W-1:0] txn_data,
   output logic              txn_write,
   output logic [SLV_W-1:0]  txn_slv,
   output logic              txn_err,
   output logic [WAIT_W-1:0] txn_wait,
   output logic [CNT_W-1:0]  txn_count,
   output logic [4:0]        viol_flags
);

   // State names the phase of the most recently sampled bus cycle.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   function automatic logic f_multi_hot(input logic [NUM_SLV-1:0] sel);
      return (sel & (sel - NUM_SLV'(1))) != {NUM_SLV{1'b0}};
   endfunction

   function automatic logic [SLV_W-1:0] f_onehot_idx(input logic [NUM_SLV-1:0] sel);
      logic [SLV_W-1:0] idx;
      idx = {SLV_W{1'b0}};
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel[i]) idx = SLV_W'(i);
      end
      return idx;
   endfunction

   logic [1:0]         r_state;
   logic [WAIT_W-1:0]  r_wait;
   logic [ADDR_W-1:0]  r_cap_addr;
   logic [DATA_W-1:0]  r_cap_wdata;
   logic [NUM_SLV-1:0] r_cap_psel;
   logic               r_cap_write;
   logic               r_valid;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_data;
   logic               r_write;
   logic [SLV_W-1:0]   r_slv;
   logic               r_err;
   logic [WAIT_W-1:0]  r_twait;
   logic [CNT_W-1:0]   r_count;
   logic [4:0]         r_viol;

   logic               w_multi;
   logic [NUM_SLV-1:0] w_psel;
   logic               w_psel_any;
   logic               w_unstable;
   logic [1:0]         w_state_nxt;
   logic [WAIT_W-1:0]  w_wait_nxt;
   logic               w_capture;
   logic               w_complete;
   logic [4:0]         w_viol_new;

   assign w_multi    = f_multi_hot(PSEL);
   assign w_psel     = w_multi ? {NUM_SLV{1'b0}} : PSEL;
   assign w_psel_any = |w_psel;
   assign w_unstable = (PADDR != r_cap_addr) || (PWRITE != r_cap_write) || (w_psel != r_cap_psel) ||
                       (r_cap_write && (PWDATA != r_cap_wdata));

   // Phase tracking, completion detection and violation detection for the sampled cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_capture   = 1'b0;
      w_complete  = 1'b0;
      w_viol_new  = {4'b0000, w_multi};
      case (r_state)
         ST_IDLE: begin
            w_wait_nxt = {WAIT_W{1'b0}};
            if (w_psel_any && !PENABLE) begin
               w_state_nxt = ST_SETUP;
               w_capture   = 1'b1;
            end else if (w_psel_any) begin
               w_viol_new[1] = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP, ST_ACCESS: begin
            if (!w_psel_any) begin
               w_viol_new[3] = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else if ((r_state == ST_SETUP) && !(PENABLE && (w_psel == r_cap_psel))) begin
               w_viol_new[1] = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else begin
               // This sample is an access cycle: check stability, then ready/wait/timeout.
               w_viol_new[2] = w_unstable;
               if (PREADY) begin
                  w_complete  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (r_wait == WAIT_LAST) begin
                  w_viol_new[4] = 1'b1;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_wait_nxt  = r_wait + WAIT_W'(1);
                  w_state_nxt = ST_ACCESS;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_wait_nxt  = {WAIT_W{1'b0}};
         end
      endcase
   end

   // Phase state, wait counter and SETUP-phase capture.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ST_IDLE;
         r_wait      <= {WAIT_W{1'b0}};
         r_cap_addr  <= {ADDR_W{1'b0}};
         r_cap_wdata <= {DATA_W{1'b0}};
         r_cap_psel  <= {NUM_SLV{1'b0}};
         r_cap_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         if (w_capture) begin
            r_cap_addr  <= PADDR;
            r_cap_wdata <= PWDATA;
            r_cap_psel  <= w_psel;
            r_cap_write <= PWRITE;
         end
      end
   end

   // Transaction record and saturating count.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_valid <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
         r_data  <= {DATA_W{1'b0}};
         r_write <= 1'b0;
         r_slv   <= {SLV_W{1'b0}};
         r_err   <= 1'b0;
         r_twait <= {WAIT_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         r_valid <= w_complete;
         if (w_complete) begin
            r_addr  <= r_cap_addr;
            r_data  <= r_cap_write ? r_cap_wdata : PRDATA;
            r_write <= r_cap_write;
            r_slv   <= f_onehot_idx(r_cap_psel);
            r_err   <= PSLVERR;
            r_twait <= r_wait;
            if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
         end
      end
   end

   // Sticky violation flags; a same-cycle detection wins over the clear.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_viol <= 5'b00000;
      end else if (viol_clr) begin
         r_viol <= w_viol_new;
      end else begin
         r_viol <= r_viol | w_viol_new;
      end
   end

   assign txn_valid  = r_valid;
   assign txn_addr   = r_addr;
   assign txn_data   = r_data;
   assign txn_write  = r_write;
   assign txn_slv    = r_slv;
   assign txn_err    = r_err;
   assign txn_wait   = r_twait;
   assign txn_count  = r_count;
   assign viol_flags = r_viol;

endmodule

// File: tb/tb_apb_txn_monitor.sv
// Self-checking bench for apb_txn_monitor: directed scenarios plus randomized legal traffic checked
// against records predicted from the transfers the bench itself issues.
module tb_apb_txn_monitor;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int REC_W   = 1 + 32 + 32 + 1 + 2 + 1 + 5 + CNT_W;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic [31:0] PADDR = '0, PWDATA = '0, PRDATA = '0;
   logic [2:0]  PSEL = '0;
   logic        PWRITE = 1'b0, PENABLE = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0, viol_clr = 1'b0;
   logic        txn_valid, txn_write, txn_err;
   logic [31:0] txn_addr, txn_data;
   logic [1:0]  txn_slv;
   logic [4:0]  txn_wait, viol_flags;
   logic [CNT_W-1:0] txn_count;

   int vectors = 0;
   int miscompares = 0;
   int exp_count = 0;
   int cyc = 0;
   logic [REC_W-1:0] obs_rec, exp_rec;

   apb_txn_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .MAX_WAIT(16), .CNT_W(CNT_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PSEL(PSEL), .PWRITE(PWRITE), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .viol_clr(viol_clr), .txn_valid(txn_valid), .txn_addr(txn_addr), .txn_data(txn_data),
      .txn_write(txn_write), .txn_slv(txn_slv), .txn_err(txn_err), .txn_wait(txn_wait),
      .txn_count(txn_count), .viol_flags(viol_flags));

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;
   assign obs_rec = {txn_valid, txn_addr, txn_data, txn_write, txn_slv, txn_err, txn_wait, txn_count};

   function automatic logic [REC_W-1:0] mk_rec(input logic v, input logic [31:0] a, input logic [31:0] d,
                                                input logic w, input int slv, input logic e,
                                                input int wt, input int cnt);
      return {v, a, d, w, 2'(slv), e, 5'(wt), CNT_W'(cnt)};
   endfunction

   task automatic drive(input logic [2:0] psel, input logic en, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic rdy, input logic err);
      PSEL = psel; PENABLE = en; PADDR = addr; PWRITE = wr;
      PWDATA = wd; PRDATA = rd; PREADY = rdy; PSLVERR = err;
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(3'b000, 1'b0, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
   endtask

   // One legal transfer; returns just after the edge that samples PREADY=1.
   task automatic xfer(input int slv, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits, input logic err);
      logic [2:0] sel;
      sel = 3'(1 << slv);
      drive(sel, 1'b0, addr, wr, wd, $urandom, 1'($urandom), 1'b0);
      for (int i = 0; i < waits; i++) drive(sel, 1'b1, addr, wr, wd, $urandom, 1'b0, 1'($urandom));
      drive(sel, 1'b1, addr, wr, wd, rd, 1'b1, err);
   endtask

   task automatic apply_reset();
      HRESETn = 1'b0;
      viol_clr = 1'b0;
      idle(2);
      HRESETn = 1'b1;
      exp_count = 0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      #1;
      vectors++;
      if (obs_rec !== '0) begin miscompares++; $display("FAIL reset_rec got %h exp 0", obs_rec); end
      vectors++;
      if (viol_flags !== 5'b00000) begin miscompares++; $display("FAIL reset_flags got %b exp 00000", viol_flags); end
      apply_reset();
   endtask

   task automatic test_write_basic();
      apply_reset();
      idle(1);
      xfer(1, 32'h40, 1'b1, 32'hDEADBEEF, $urandom, 0, 1'b0);
      exp_count++;
      exp_rec = mk_rec(1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL write_rec got %h exp %h", obs_rec, exp_rec); end
      vectors++;
      if (viol_flags !== 5'b00000) begin miscompares++; $display("FAIL write_flags got %b exp 00000", viol_flags); end
      idle(1);
      exp_rec = mk_rec(1'b0, 32'h40, 32'hDEADBEEF, 1'b1, 1, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL write_hold got %h exp %h", obs_rec, exp_rec); end
   endtask

   task automatic test_read_wait();
      logic [31:0] a;
      apply_reset();
      a = $urandom;
      xfer(2, a, 1'b0, $urandom, 32'h1234, 3, 1'b1);
      exp_count++;
      exp_rec = mk_rec(1'b1, a, 32'h1234, 1'b0, 2, 1'b1, 3, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL read_rec got %h exp %h", obs_rec, exp_rec); end
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, a1, d0, d1;
      int t0, t1;
      apply_reset();
      a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
      xfer(0, a0, 1'b1, d0, $urandom, 0, 1'b0);
      t0 = cyc;
      exp_count++;
      exp_rec = mk_rec(1'b1, a0, d0, 1'b1, 0, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL b2b_rec0 got %h exp %h", obs_rec, exp_rec); end
      xfer(2, a1, 1'b1, d1, $urandom, 0, 1'b0);
      t1 = cyc;
      exp_count++;
      exp_rec = mk_rec(1'b1, a1, d1, 1'b1, 2, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL b2b_rec1 got %h exp %h", obs_rec, exp_rec); end
      vectors++;
      if (t1 - t0 !== 2) begin miscompares++; $display("FAIL b2b_spacing got %0d exp 2", t1 - t0); end
      idle(1);
      vectors++;
      if (viol_flags !== 5'b00000) begin miscompares++; $display("FAIL b2b_flags got %b exp 00000", viol_flags); end
   endtask

   task automatic test_wait_timeout();
      logic [31:0] a;
      logic seen;
      apply_reset();
      a = $urandom;
      xfer(1, a, 1'b0, $urandom, 32'h0BADF00D, 15, 1'b0);
      exp_count++;
      exp_rec = mk_rec(1'b1, a, 32'h0BADF00D, 1'b0, 1, 1'b0, 15, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL wait15_rec got %h exp %h", obs_rec, exp_rec); end
      idle(1);
      seen = 1'b0;
      drive(3'b001, 1'b0, a, 1'b1, 32'h55, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         drive(3'b001, 1'b1, a, 1'b1, 32'h55, $urandom, 1'b0, 1'b0);
         seen = seen | txn_valid;
      end
      idle(1);
      seen = seen | txn_valid;
      vectors++;
      if (seen !== 1'b0) begin miscompares++; $display("FAIL timeout_no_rec got %b exp 0", seen); end
      vectors++;
      if (viol_flags !== 5'b10000) begin miscompares++; $display("FAIL timeout_flags got %b exp 10000", viol_flags); end
      xfer(0, a, 1'b1, 32'h77, $urandom, 0, 1'b0);
      exp_count++;
      exp_rec = mk_rec(1'b1, a, 32'h77, 1'b1, 0, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL after_timeout_rec got %h exp %h", obs_rec, exp_rec); end
      idle(1);
   endtask

   task automatic test_violations();
      logic [31:0] a, d;
      apply_reset();
      drive(3'b010, 1'b1, $urandom, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
      idle(1);
      vectors++;
      if (viol_flags !== 5'b00010) begin miscompares++; $display("FAIL no_setup got %b exp 00010", viol_flags); end
      viol_clr = 1'b1; idle(1); viol_clr = 1'b0;
      vectors++;
      if (viol_flags !== 5'b00000) begin miscompares++; $display("FAIL clr got %b exp 00000", viol_flags); end
      a = $urandom & 32'hFFFF_FFF0; d = $urandom;
      drive(3'b001, 1'b0, a, 1'b1, d, $urandom, 1'b0, 1'b0);
      drive(3'b001, 1'b1, a ^ 32'h4, 1'b1, d, $urandom, 1'b1, 1'b0);
      exp_count++;
      exp_rec = mk_rec(1'b1, a, d, 1'b1, 0, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL unstable_rec got %h exp %h", obs_rec, exp_rec); end
      idle(1);
      vectors++;
      if (viol_flags !== 5'b00100) begin miscompares++; $display("FAIL unstable got %b exp 00100", viol_flags); end
      viol_clr = 1'b1; idle(1); viol_clr = 1'b0;
      drive(3'b011, 1'b0, $urandom, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      idle(1);
      vectors++;
      if (viol_flags !== 5'b00001) begin miscompares++; $display("FAIL multi_hot got %b exp 00001", viol_flags); end
      viol_clr = 1'b1;
      drive(3'b010, 1'b1, $urandom, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
      viol_clr = 1'b0;
      idle(1);
      vectors++;
      if (viol_flags !== 5'b00010) begin miscompares++; $display("FAIL clr_priority got %b exp 00010", viol_flags); end
      viol_clr = 1'b1; idle(1); viol_clr = 1'b0;
      drive(3'b010, 1'b0, a, 1'b0, d, $urandom, 1'b0, 1'b0);
      drive(3'b000, 1'b1, a, 1'b0, d, $urandom, 1'b1, 1'b0);
      idle(1);
      vectors++;
      if (viol_flags !== 5'b01000) begin miscompares++; $display("FAIL psel_drop got %b exp 01000", viol_flags); end
      vectors++;
      if (txn_count !== CNT_W'(exp_count)) begin miscompares++; $display("FAIL psel_drop_cnt got %0d exp %0d", txn_count, exp_count); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      xfer(2, 32'h100, 1'b1, 32'h5A5A, $urandom, 1, 1'b0);
      idle(1);
      drive(3'b001, 1'b0, 32'h200, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      drive(3'b001, 1'b1, 32'h200, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      drive(3'b001, 1'b1, 32'h200, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      #2;
      HRESETn = 1'b0;
      #1;
      vectors++;
      if (obs_rec !== '0) begin miscompares++; $display("FAIL mid_reset_rec got %h exp 0", obs_rec); end
      vectors++;
      if (viol_flags !== 5'b00000) begin miscompares++; $display("FAIL mid_reset_flags got %b exp 00000", viol_flags); end
      idle(1);
      HRESETn = 1'b1;
      exp_count = 0;
      idle(1);
      xfer(0, 32'h300, 1'b1, 32'h1111, $urandom, 0, 1'b0);
      exp_count++;
      exp_rec = mk_rec(1'b1, 32'h300, 32'h1111, 1'b1, 0, 1'b0, 0, exp_count);
      vectors++;
      if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL post_reset_rec got %h exp %h", obs_rec, exp_rec); end
      idle(1);
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rd;
      logic wr, err;
      int slv, waits;
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         idle($urandom_range(0, 2));
         slv = $urandom_range(0, 2); waits = $urandom_range(0, 15);
         a = $urandom; wd = $urandom; rd = $urandom; wr = 1'($urandom); err = 1'($urandom);
         xfer(slv, a, wr, wd, rd, waits, err);
         if (exp_count < CNT_MAX) exp_count++;
         exp_rec = mk_rec(1'b1, a, wr ? wd : rd, wr, slv, err, waits, exp_count);
         vectors++;
         if (obs_rec !== exp_rec) begin miscompares++; $display("FAIL rand_rec%0d got %h exp %h", n, obs_rec, exp_rec); end
      end
      idle(1);
      vectors++;
      if (txn_count !== CNT_W'(CNT_MAX)) begin miscompares++; $display("FAIL rand_sat got %0d exp %0d", txn_count, CNT_MAX); end
      vectors++;
      if (viol_flags !== 5'b00000) begin miscompares++; $display("FAIL rand_flags got %b exp 00000", viol_flags); end
   endtask

   initial begin
      #2;
      test_reset();
      test_write_basic();
      test_read_wait();
      test_back_to_back();
      test_wait_timeout();
      test_violations();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
